sr_flag_controller: RTL

Sequencing controller and round-robin arbiter for a bank of `NFLAGS` SR flip-flops shared by `NREQ` requesters. Each requester asks to set or clear one flag. The block arbitrates, drives exactly one S or R pulse into the bank, and acknowledges the requester with `done`. It also clears the whole bank after reset, since the SR cell has no reset of its own. The block never presents S=R=1 to any flop.

---
 rtl/sr_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/sr_flip_flop.sv | 22 ++
 rtl/sr_flag_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared state encodings and op codes for the SR flag controller.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after pointer+1, wrapping.
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_valid,
    output logic [PTRW-1:0] o_idx
);

    int unsigned w_cand;

    // Scan requesters in rotated order starting just after the last winner.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = (32'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[PTRW'(w_cand)]) begin
                o_valid               = 1'b1;
                o_idx                 = PTRW'(w_cand);
                o_gnt[PTRW'(w_cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_flip_flop.sv
// Clocked SR storage cell with no reset of its own; the controller clears it.
module sr_flip_flop (
    input  logic i_clk,
    input  logic i_s,
    input  logic i_r,
    output logic o_q
);

    logic r_q;

    // Set takes priority; the controller never presents S and R together.
    always_ff @(posedge i_clk) begin
        if (i_s) begin
            r_q <= 1'b1;
        end else if (i_r) begin
            r_q <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sr_flag_controller.sv
// Arbitrates set/clear requests onto a bank of SR flags, one S or R pulse per op.
module sr_flag_controller
    import sr_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned NFLAGS = 8,
    localparam int unsigned IDXW   = $clog2(NFLAGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_op,
    input  logic [NREQ*IDXW-1:0] i_idx,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic [NFLAGS-1:0]    o_flags,
    output logic                 o_ready
);

    localparam int unsigned PTRW = $clog2(NREQ);

    state_t              r_state;
    logic [PTRW-1:0]     r_ptr;
    logic [NREQ-1:0]     r_win;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic                r_ready;
    logic [NFLAGS-1:0]   r_s;
    logic [NFLAGS-1:0]   r_r;

    logic [NREQ-1:0]     w_win;
    logic                w_valid;
    logic [PTRW-1:0]     w_win_idx;
    logic                w_sel_op;
    logic [IDXW-1:0]     w_sel_idx;
    logic [NFLAGS-1:0]   w_dec;
    logic [NFLAGS-1:0]   w_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_win),
        .o_valid (w_valid),
        .o_idx   (w_win_idx)
    );

    // Select the winner's op and index, and decode the index to a one-hot flag mask.
    always_comb begin
        w_sel_op  = OP_CLR;
        w_sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_sel_op  = i_op[i];
                w_sel_idx = i_idx[i*IDXW +: IDXW];
            end
        end
        w_dec = NFLAGS'(1) << w_sel_idx;
    end

    // Sequencer: INIT clears the bank, IDLE grants, DRIVE pulses S/R, ACK reports done.
    // The registered S/R pair doubles as the latched op/idx of the granted request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_gnt   <= '0;
            r_done  <= '0;
            r_ready <= 1'b0;
            r_win   <= '0;
            r_s     <= '0;
            r_r     <= '1;
            r_ptr   <= PTRW'(NREQ - 1);
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_s     <= '0;
                    r_r     <= '0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_s <= '0;
                    r_r <= '0;
                    if (w_valid) begin
                        r_ptr   <= w_win_idx;
                        r_win   <= w_win;
                        r_gnt   <= w_win;
                        r_s     <= (w_sel_op == OP_SET) ? w_dec : '0;
                        r_r     <= (w_sel_op == OP_SET) ? '0 : w_dec;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_gnt   <= '0;
                    r_s     <= '0;
                    r_r     <= '0;
                    r_done  <= r_win;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Flag bank: one SR cell per flag, driven only from registered S/R.
    genvar g;
    generate
        for (g = 0; g < NFLAGS; g++) begin : g_bank
            sr_flip_flop u_ff (
                .i_clk (i_clk),
                .i_s   (r_s[g]),
                .i_r   (r_r[g]),
                .o_q   (w_q[g])
            );
        end
    endgenerate

    assign o_gnt   = r_gnt;
    assign o_done  = r_done;
    assign o_ready = r_ready;
    assign o_flags = w_q;

endmodule
